// File: rtl/mole_pkg.sv
// Shared types and helpers for the mole scheduler. With MOLE_FLASH_EN defined,
// each slot also stores the lifetime it was loaded with.
package mole_pkg;

  localparam int LED_COUNT = 18;
  localparam int IDX_W     = $clog2(LED_COUNT);

  localparam logic [1:0] LVL_0 = 2'b00;
  localparam logic [1:0] LVL_1 = 2'b01;
  localparam logic [1:0] LVL_2 = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [31:0]      timer;
`ifdef MOLE_FLASH_EN
    logic [31:0]      life;
`endif
  } slot_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [5:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {11'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One lifetime slot: load, hit-clear, expiry detect and countdown.
// Under MOLE_FLASH_EN the lit output blinks during the last quarter of life.
module mole_slot import mole_pkg::*;
`ifdef MOLE_FLASH_EN
  #(parameter int unsigned FLASH_BIT = 22)
`endif
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [IDX_W-1:0]     load_idx_i,
  input  logic [31:0]          load_life_i,
  input  logic [LED_COUNT-1:0] hit_mask_i,
  output logic                 valid_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 lit_o,
  output logic                 expire_o,
  output logic                 hit_now_o
);

  slot_t slot_q, slot_d;

  // A hit wins over expiry when both land in the same cycle.
  assign hit_now_o = en_i && slot_q.valid && hit_mask_i[slot_q.idx];
  assign expire_o  = en_i && slot_q.valid && !hit_now_o && (slot_q.timer == 32'd0);
  assign valid_o   = slot_q.valid;
  assign idx_o     = slot_q.idx;

`ifdef MOLE_FLASH_EN
  assign lit_o = slot_q.valid &&
                 !((slot_q.timer < (slot_q.life >> 2)) && !slot_q.timer[FLASH_BIT]);
`else
  assign lit_o = slot_q.valid;
`endif

  always_comb begin
    slot_d = slot_q;
    if (!en_i) begin
      slot_d.valid = 1'b0;
    end else if (load_i) begin
      slot_d.valid = 1'b1;
      slot_d.idx   = load_idx_i;
      slot_d.timer = load_life_i - 32'd1;
`ifdef MOLE_FLASH_EN
      slot_d.life  = load_life_i;
`endif
    end else if (hit_now_o || expire_o) begin
      slot_d.valid = 1'b0;
    end else if (slot_q.valid) begin
      slot_d.timer = slot_q.timer - 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) slot_q <= '0;
    else       slot_q <= slot_d;
  end

endmodule

// File: rtl/mole_scheduler.sv
// Allocates LED requests to lifetime slots, times them out, and reports
// hit/miss/wrong/drop events with saturating tallies. Optional: MOLE_FLASH_EN.
module mole_scheduler import mole_pkg::*; #(
  parameter int unsigned MAX_ACTIVE = 4,
  parameter int unsigned LIFE_LVL0  = 100_000_000,
  parameter int unsigned LIFE_LVL1  = 40_000_000,
  parameter int unsigned LIFE_LVL2  = 20_000_000
`ifdef MOLE_FLASH_EN
  , parameter int unsigned FLASH_BIT = 22
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [1:0]                      level,
  input  logic                            req_valid,
  input  logic [IDX_W-1:0]                req_index,
  input  logic [LED_COUNT-1:0]            hit_mask,
  output logic [LED_COUNT-1:0]            led_on,
  output logic                            hit_pulse,
  output logic                            miss_pulse,
  output logic                            wrong_pulse,
  output logic                            drop_pulse,
  output logic [$clog2(MAX_ACTIVE+1)-1:0] active_count,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
);

  localparam int CNT_W = $clog2(MAX_ACTIVE+1);

  logic [MAX_ACTIVE-1:0] slot_valid, slot_lit, slot_expire, slot_hit, slot_load, free_sel;
  logic [IDX_W-1:0]      slot_idx [MAX_ACTIVE];
  logic [LED_COUNT-1:0]  valid_mask;
  logic [31:0]           life_sel;
  logic [5:0]            valid_cnt;
  logic                  any_free, dup, in_range, accept;

  logic        hit_pulse_q, miss_pulse_q, wrong_pulse_q, drop_pulse_q;
  logic        hit_pulse_d, miss_pulse_d, wrong_pulse_d, drop_pulse_d;
  logic [15:0] hit_count_q, miss_count_q, hit_count_d, miss_count_d;

  for (genvar g = 0; g < MAX_ACTIVE; g++) begin : g_slot
    mole_slot
`ifdef MOLE_FLASH_EN
      #(.FLASH_BIT(FLASH_BIT))
`endif
      u_slot (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (enable),
        .load_i      (slot_load[g]),
        .load_idx_i  (req_index),
        .load_life_i (life_sel),
        .hit_mask_i  (hit_mask),
        .valid_o     (slot_valid[g]),
        .idx_o       (slot_idx[g]),
        .lit_o       (slot_lit[g]),
        .expire_o    (slot_expire[g]),
        .hit_now_o   (slot_hit[g])
      );
  end

  always_comb begin
    case (level)
      LVL_1:   life_sel = LIFE_LVL1;
      LVL_2:   life_sel = LIFE_LVL2;
      default: life_sel = LIFE_LVL0;
    endcase
  end

  // Everything below looks at pre-update slot state, so a slot freed this
  // cycle is not reusable and an LED being hit still counts as lit.
  always_comb begin
    free_sel   = '0;
    any_free   = 1'b0;
    led_on     = '0;
    valid_mask = '0;
    dup        = 1'b0;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      if (!slot_valid[i] && !any_free) begin
        free_sel[i] = 1'b1;
        any_free    = 1'b1;
      end
      if (slot_lit[i]) led_on[slot_idx[i]] = 1'b1;
      if (slot_valid[i]) begin
        valid_mask[slot_idx[i]] = 1'b1;
        if (slot_idx[i] == req_index) dup = 1'b1;
      end
    end
  end

  assign in_range  = int'(req_index) < LED_COUNT;
  assign accept    = enable && req_valid && in_range && !dup && any_free;
  assign slot_load = accept ? free_sel : '0;
  assign valid_cnt = popcount(32'(slot_valid));
  assign active_count = CNT_W'(valid_cnt);

  always_comb begin
    hit_pulse_d   = |slot_hit;
    miss_pulse_d  = |slot_expire;
    wrong_pulse_d = enable && |(hit_mask & ~valid_mask);
    drop_pulse_d  = enable && req_valid && !accept;
    hit_count_d   = sat_add16(hit_count_q, popcount(32'(slot_hit)));
    miss_count_d  = sat_add16(miss_count_q, popcount(32'(slot_expire)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_pulse_q   <= 1'b0;
      miss_pulse_q  <= 1'b0;
      wrong_pulse_q <= 1'b0;
      drop_pulse_q  <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      hit_pulse_q   <= hit_pulse_d;
      miss_pulse_q  <= miss_pulse_d;
      wrong_pulse_q <= wrong_pulse_d;
      drop_pulse_q  <= drop_pulse_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign hit_pulse   = hit_pulse_q;
  assign miss_pulse  = miss_pulse_q;
  assign wrong_pulse = wrong_pulse_q;
  assign drop_pulse  = drop_pulse_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with lifetimes shortened to 10/6/4 cycles.
module tb_mole_scheduler;

  logic        clk = 1'b0;
  logic        rst, enable, req_valid;
  logic [1:0]  level;
  logic [4:0]  req_index;
  logic [17:0] hit_mask;
  logic [17:0] led_on;
  logic        hit_pulse, miss_pulse, wrong_pulse, drop_pulse;
  logic [2:0]  active_count;
  logic [15:0] hit_count, miss_count;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_hits = '0;
  logic [15:0] exp_misses = '0;

  always #5 clk = ~clk;

  mole_scheduler #(
    .MAX_ACTIVE(4), .LIFE_LVL0(10), .LIFE_LVL1(6), .LIFE_LVL2(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .level(level),
    .req_valid(req_valid), .req_index(req_index), .hit_mask(hit_mask),
    .led_on(led_on), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .wrong_pulse(wrong_pulse), .drop_pulse(drop_pulse),
    .active_count(active_count), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input logic [4:0] idx, input logic [1:0] lvl);
    req_valid = 1'b1;
    req_index = idx;
    level     = lvl;
    cyc();
    req_valid = 1'b0;
  endtask

  // Allocates LED 8 (10 cycles) then LED 9 four edges later (6 cycles) so both
  // expire on the same edge; returns edges counted after the second request.
  task automatic run_double_miss(output int k);
    req(5'd8, 2'b00);
    level = 2'b10;
    cyc(); cyc(); cyc();
    req(5'd9, 2'b01);
    level = 2'b10;
    k = 0;
    while (!miss_pulse && k < 20) begin
      cyc();
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; level = 2'b00;
    req_valid = 1'b0; req_index = '0; hit_mask = '0;
    cyc(); cyc();
    checks++; if (led_on !== 18'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led_on); end
    checks++; if ({hit_pulse, miss_pulse, wrong_pulse, drop_pulse} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {hit_pulse, miss_pulse, wrong_pulse, drop_pulse}); end
    checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active_count); end
    checks++; if ({hit_count, miss_count} !== 32'h0) begin failures++; $display("FAIL reset_tallies got=%h/%h exp=0/0", hit_count, miss_count); end
    rst = 1'b0;
  endtask

  task automatic test_expiry();
    int lit;
    req(5'd5, 2'b00);
    lit = 0;
    while (led_on[5] && lit < 20) begin
      lit++;
      cyc();
    end
    exp_misses = 16'd1;
    checks++; if (lit !== 10) begin failures++; $display("FAIL expiry_lit_cycles got=%0d exp=10", lit); end
    checks++; if (miss_pulse !== 1'b1) begin failures++; $display("FAIL expiry_miss_pulse got=%b exp=1", miss_pulse); end
    checks++; if (miss_count !== exp_misses) begin failures++; $display("FAIL expiry_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
    checks++; if (active_count !== 3'd0) begin failures++; $display("FAIL expiry_active got=%0d exp=0", active_count); end
    cyc();
    checks++; if (miss_pulse !== 1'b0) begin failures++; $display("FAIL expiry_pulse_single got=%b exp=0", miss_pulse); end
  endtask

  task automatic test_hit();
    int misses;
    req(5'd3, 2'b01);
    cyc(); cyc();
    hit_mask = 18'h00008;
    cyc();
    hit_mask = '0;
    exp_hits = 16'd1;
    checks++; if (led_on[3] !== 1'b0) begin failures++; $display("FAIL hit_led_off got=%b exp=0", led_on[3]); end
    checks++; if (hit_pulse !== 1'b1) begin failures++; $display("FAIL hit_pulse got=%b exp=1", hit_pulse); end
    checks++; if (wrong_pulse !== 1'b0) begin failures++; $display("FAIL hit_wrong got=%b exp=0", wrong_pulse); end
    checks++; if (hit_count !== exp_hits) begin failures++; $display("FAIL hit_count got=%0d exp=%0d", hit_count, exp_hits); end
    misses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (miss_pulse) misses++;
    end
    checks++; if (misses !== 0 || miss_count !== exp_misses) begin failures++; $display("FAIL hit_no_miss got=%0d/%0d exp=0/%0d", misses, miss_count, exp_misses); end
  endtask

  task automatic test_capacity();
    for (int i = 0; i < 5; i++) req(5'(i), 2'b00);
    checks++; if (led_on !== 18'h0000F) begin failures++; $display("FAIL cap_led got=%h exp=0000f", led_on); end
    checks++; if (active_count !== 3'd4) begin failures++; $display("FAIL cap_active got=%0d exp=4", active_count); end
    checks++; if (drop_pulse !== 1'b1) begin failures++; $display("FAIL cap_full_drop got=%b exp=1", drop_pulse); end
    hit_mask = 18'h00001;
    cyc();
    hit_mask = '0;
    exp_hits = exp_hits + 16'd1;
    checks++; if (led_on !== 18'h0000E || drop_pulse !== 1'b0) begin failures++; $display("FAIL cap_hit0 got=%h/%b exp=0000e/0", led_on, drop_pulse); end
    req(5'd2, 2'b00);
    checks++; if (drop_pulse !== 1'b1 || active_count !== 3'd3) begin failures++; $display("FAIL cap_dup_drop got=%b/%0d exp=1/3", drop_pulse, active_count); end
    req(5'd20, 2'b00);
    checks++; if (drop_pulse !== 1'b1 || led_on !== 18'h0000E) begin failures++; $display("FAIL cap_range_drop got=%b/%h exp=1/0000e", drop_pulse, led_on); end
    hit_mask = 18'h00002;
    req(5'd1, 2'b00);
    hit_mask = '0;
    exp_hits = exp_hits + 16'd1;
    checks++; if (drop_pulse !== 1'b1 || hit_pulse !== 1'b1 || led_on !== 18'h0000C) begin failures++; $display("FAIL cap_hit_req_same got=%b/%b/%h exp=1/1/0000c", drop_pulse, hit_pulse, led_on); end
    checks++; if (hit_count !== exp_hits) begin failures++; $display("FAIL cap_hit_count got=%0d exp=%0d", hit_count, exp_hits); end
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    checks++; if (led_on !== 18'h0 || active_count !== 3'd0) begin failures++; $display("FAIL cap_clear got=%h/%0d exp=0/0", led_on, active_count); end
    for (int i = 0; i < 6; i++) cyc();
    checks++; if (miss_count !== exp_misses) begin failures++; $display("FAIL cap_no_miss got=%0d exp=%0d", miss_count, exp_misses); end
  endtask

  task automatic test_hit_expire_same();
    req(5'd6, 2'b10);
    cyc(); cyc(); cyc();
    hit_mask = 18'h000C0;
    cyc();
    hit_mask = '0;
    exp_hits = exp_hits + 16'd1;
    checks++; if ({hit_pulse, miss_pulse, wrong_pulse} !== 3'b101) begin failures++; $display("FAIL same_pulses got=%b exp=101", {hit_pulse, miss_pulse, wrong_pulse}); end
    checks++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin failures++; $display("FAIL same_tallies got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    checks++; if (led_on !== 18'h0) begin failures++; $display("FAIL same_led got=%h exp=0", led_on); end
    cyc();
    checks++; if ({hit_pulse, miss_pulse, wrong_pulse} !== 3'b000) begin failures++; $display("FAIL same_pulses_clear got=%b exp=000", {hit_pulse, miss_pulse, wrong_pulse}); end
  endtask

  task automatic test_double_miss();
    int k;
    run_double_miss(k);
    exp_misses = exp_misses + 16'd2;
    checks++; if (k !== 6) begin failures++; $display("FAIL dbl_latency got=%0d exp=6", k); end
    checks++; if (miss_count !== exp_misses) begin failures++; $display("FAIL dbl_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
    checks++; if (led_on !== 18'h0) begin failures++; $display("FAIL dbl_led got=%h exp=0", led_on); end
    cyc();
  endtask

  task automatic test_saturate();
    int k;
    force dut.miss_count_q = 16'hFFFE;
    #1;
    release dut.miss_count_q;
    run_double_miss(k);
    exp_misses = 16'hFFFF;
    checks++; if (miss_count !== exp_misses) begin failures++; $display("FAIL sat_miss_count got=%h exp=%h", miss_count, exp_misses); end
    cyc();
  endtask

  task automatic test_enable();
    int misses;
    req(5'd10, 2'b00); req(5'd11, 2'b00); req(5'd12, 2'b00);
    checks++; if (led_on !== 18'h01C00 || active_count !== 3'd3) begin failures++; $display("FAIL en_setup got=%h/%0d exp=01c00/3", led_on, active_count); end
    enable = 1'b0;
    cyc();
    checks++; if (led_on !== 18'h0 || active_count !== 3'd0) begin failures++; $display("FAIL en_clear got=%h/%0d exp=0/0", led_on, active_count); end
    hit_mask = 18'h02000;
    req(5'd13, 2'b00);
    hit_mask = '0;
    checks++; if ({hit_pulse, miss_pulse, wrong_pulse, drop_pulse} !== 4'b0 || led_on !== 18'h0) begin failures++; $display("FAIL en_ignore got=%b/%h exp=0000/0", {hit_pulse, miss_pulse, wrong_pulse, drop_pulse}, led_on); end
    checks++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin failures++; $display("FAIL en_tallies got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
    enable = 1'b1;
    misses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (miss_pulse) misses++;
    end
    checks++; if (misses !== 0) begin failures++; $display("FAIL en_no_late_miss got=%0d exp=0", misses); end
  endtask

  task automatic test_reset_mid();
    int misses;
    req(5'd14, 2'b00);
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (led_on !== 18'h0 || active_count !== 3'd0) begin failures++; $display("FAIL rstmid_led got=%h/%0d exp=0/0", led_on, active_count); end
    checks++; if ({hit_count, miss_count} !== 32'h0) begin failures++; $display("FAIL rstmid_tallies got=%h/%h exp=0/0", hit_count, miss_count); end
    misses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (miss_pulse) misses++;
    end
    checks++; if (misses !== 0 || miss_count !== 16'h0) begin failures++; $display("FAIL rstmid_no_miss got=%0d/%0d exp=0/0", misses, miss_count); end
  endtask

  initial begin
    test_reset();
    test_expiry();
    test_hit();
    test_capacity();
    test_hit_expire_same();
    test_double_miss();
    test_saturate();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
